fetch_buffer: RTL and testbench

- Parametrised instruction-fetch front end between the pipelined MIPS core and a synchronous instruction memory with configurable read latency.
- Replaces the ad-hoc scheme of gating the ROM enable with the decode stall and resetting it on branch-taken.
- Prefetches sequential PCs into a small FIFO, tags each word with its PC, and absorbs decode stalls without losing fetched words.
- Supports a same-cycle redirect (taken branch/jump) that squashes all queued and in-flight fetches.

---
 rtl/fetch_buffer_pkg.sv | 15 +
 rtl/fetch_buffer_if.sv | 35 +++
 rtl/fetch_buffer_sync_fifo.sv | 62 ++++++
 rtl/fetch_buffer.sv | 115 +++++++++++
 tb/tb_fetch_buffer.sv | 205 ++++++++++++++++++++
 5 files changed

// File: rtl/fetch_buffer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_buffer_pkg
//  Description : Shared constants for the instruction-fetch front end:
//                instruction size, default reset PC and NOP encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package fetch_buffer_pkg;

    localparam int          INSTR_BYTES  = 4;
    localparam logic [31:0] DEF_RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR    = 32'h0000_0000;

endpackage
`default_nettype wire

// File: rtl/fetch_buffer_if.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_buffer_if
//  Description : Bundle of the fetch front end's bus signals.
//                imem side : imem_en, imem_addr (out), imem_rdata (in)
//                core side : redirect, redirect_pc, stall (in)
//                            instr_valid, instr, instr_pc (out)
//                master = fetch_buffer side, slave = core/memory side.
//  Revision    : 1.0 - initial release
// ============================================================================
interface fetch_buffer_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              imem_en;
    logic [ADDR_W-1:0] imem_addr;
    logic [DATA_W-1:0] imem_rdata;
    logic              redirect;
    logic [ADDR_W-1:0] redirect_pc;
    logic              stall;
    logic              instr_valid;
    logic [DATA_W-1:0] instr;
    logic [ADDR_W-1:0] instr_pc;

    modport master (
        output imem_en, imem_addr, instr_valid, instr, instr_pc,
        input  imem_rdata, redirect, redirect_pc, stall
    );

    modport slave (
        input  imem_en, imem_addr, instr_valid, instr, instr_pc,
        output imem_rdata, redirect, redirect_pc, stall
    );
endinterface
`default_nettype wire

// File: rtl/fetch_buffer_sync_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : sync_fifo
//  Description : Single-clock FIFO with flush. Pointers carry an extra wrap
//                bit so full/empty are distinguished without a counter.
//  Ports       : clk, rst (async, active low)
//                i_push/i_data, i_pop, i_flush (flush wins over push)
//                o_data (head word), o_full, o_empty, o_count
//  Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_push,
    input  logic [DATA_W-1:0]        i_data,
    input  logic                     i_pop,
    input  logic                     i_flush,
    output logic [DATA_W-1:0]        o_data,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);
    localparam int AW = $clog2(DEPTH);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [AW:0]       r_wr_ptr;
    logic [AW:0]       r_rd_ptr;
    logic              w_wr;
    logic              w_rd;

    assign o_empty = (r_wr_ptr == r_rd_ptr);
    assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign o_count = r_wr_ptr - r_rd_ptr;
    assign o_data  = r_mem[r_rd_ptr[AW-1:0]];

    // A push into a full FIFO is only accepted when the head leaves in the
    // same cycle; a pop is never applied to an empty FIFO.
    assign w_wr = i_push && (!o_full || i_pop) && !i_flush;
    assign w_rd = i_pop && !o_empty && !i_flush;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_rd) r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr) r_mem[r_wr_ptr[AW-1:0]] <= i_data;
    end
endmodule
`default_nettype wire

// File: rtl/fetch_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_buffer
//  Description : Instruction-fetch front end. Issues sequential fetches to a
//                fixed-latency instruction memory under a credit scheme, tags
//                each returned word with its PC, queues it, and presents the
//                head to decode. A redirect squashes everything queued or in
//                flight and restarts fetch at the new PC in the same cycle.
//  Ports       : clk  - clock, rising edge
//                rst  - asynchronous, active-low reset
//                bus  - fetch_buffer_if.master (imem request/response,
//                       redirect/stall in, tagged instruction out)
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_buffer
    import fetch_buffer_pkg::*;
#(
    parameter int              ADDR_W   = 32,
    parameter int              DATA_W   = 32,
    parameter int              DEPTH    = 4,
    parameter int              MEM_LAT  = 1,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEF_RESET_PC)
) (
    input  logic           clk,
    input  logic           rst,
    fetch_buffer_if.master bus
);
    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam int OCC_W = $clog2(DEPTH + MEM_LAT + 2) + 1;

    logic [ADDR_W-1:0] r_fetch_pc;
    logic [MEM_LAT-1:0] r_fl_valid;
    logic [ADDR_W-1:0] r_fl_pc [MEM_LAT];

    logic [OCC_W-1:0]  w_inflight;
    logic [OCC_W-1:0]  w_occ;
    logic [CNT_W-1:0]  w_count;
    logic              w_empty;
    logic              w_full;
    logic              w_pop;
    logic              w_credit;
    logic [ADDR_W-1:0] w_req_addr;
    logic [ADDR_W+DATA_W-1:0] w_head;

    always_comb begin
        w_inflight = '0;
        for (int k = 0; k < MEM_LAT; k++) begin
            w_inflight = w_inflight + OCC_W'(r_fl_valid[k]);
        end
    end

    assign w_pop = !w_empty && !bus.stall && !bus.redirect;

    // Words already queued plus words still in the memory pipe must fit in
    // the FIFO; the entry leaving this cycle frees one slot.
    assign w_occ    = OCC_W'(w_count) + w_inflight;
    assign w_credit = bus.redirect || (w_occ < (OCC_W'(DEPTH) + OCC_W'(w_pop)));

    assign w_req_addr = bus.redirect ? {bus.redirect_pc[ADDR_W-1:2], 2'b00}
                                     : r_fetch_pc;

    // rst only gates the output here so no request is shown while held in
    // reset; the flops below are already frozen by the async clear.
    assign bus.imem_en   = w_credit && rst;
    assign bus.imem_addr = w_req_addr;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_fetch_pc <= RESET_PC;
        end else if (w_credit) begin
            r_fetch_pc <= w_req_addr + ADDR_W'(INSTR_BYTES);
        end
    end

    // Stage 0 takes the request issued this cycle (kept even on redirect);
    // older stages are squashed by a redirect.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_fl_valid <= '0;
            for (int k = 0; k < MEM_LAT; k++) r_fl_pc[k] <= '0;
        end else begin
            r_fl_valid[0] <= w_credit;
            r_fl_pc[0]    <= w_req_addr;
            for (int k = 1; k < MEM_LAT; k++) begin
                r_fl_valid[k] <= r_fl_valid[k-1] && !bus.redirect;
                r_fl_pc[k]    <= r_fl_pc[k-1];
            end
        end
    end

    sync_fifo #(
        .DATA_W (ADDR_W + DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (r_fl_valid[MEM_LAT-1]),
        .i_data  ({r_fl_pc[MEM_LAT-1], bus.imem_rdata}),
        .i_pop   (w_pop),
        .i_flush (bus.redirect),
        .o_data  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    assign bus.instr_valid = !w_empty;
    assign bus.instr       = w_empty ? DATA_W'(NOP_INSTR) : w_head[DATA_W-1:0];
    assign bus.instr_pc    = w_empty ? '0 : w_head[ADDR_W+DATA_W-1:DATA_W];

    // Full is implied by the credit rule and not needed for control here.
    logic w_unused;
    assign w_unused = w_full;
endmodule
`default_nettype wire

// File: tb/tb_fetch_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fetch_buffer
//  Description : Bench for fetch_buffer. Two instances (MEM_LAT=1 and 3,
//                DEPTH=4) share the same stall/redirect/reset stimulus; each
//                is compared every cycle with a transaction-level model that
//                keeps one queue of outstanding fetches per instance.
//                ROM contents: word at byte address a is a>>2.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_buffer;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;

    always #5 clk = ~clk;

    fetch_buffer_if #(.ADDR_W(32), .DATA_W(32)) bus1 ();
    fetch_buffer_if #(.ADDR_W(32), .DATA_W(32)) bus3 ();

    assign bus1.stall = stall;  assign bus1.redirect = redirect;  assign bus1.redirect_pc = redirect_pc;
    assign bus3.stall = stall;  assign bus3.redirect = redirect;  assign bus3.redirect_pc = redirect_pc;

    fetch_buffer #(.ADDR_W(32), .DATA_W(32), .DEPTH(DEPTH), .MEM_LAT(1), .RESET_PC(32'h0))
        dut1 (.clk(clk), .rst(rst), .bus(bus1));
    fetch_buffer #(.ADDR_W(32), .DATA_W(32), .DEPTH(DEPTH), .MEM_LAT(3), .RESET_PC(32'h0))
        dut3 (.clk(clk), .rst(rst), .bus(bus3));

    // Memory models: address pipelines that keep running through reset, so
    // stale words do come back after a mid-stream reset.
    logic [31:0] mp1 [1];
    logic [31:0] mp3 [3];
    always @(posedge clk) begin
        mp1[0] <= bus1.imem_addr;
        mp3[0] <= bus3.imem_addr;
        mp3[1] <= mp3[0];
        mp3[2] <= mp3[1];
    end
    assign bus1.imem_rdata = mp1[0] >> 2;
    assign bus3.imem_rdata = mp3[2] >> 2;

    logic        ob_en   [2];
    logic [31:0] ob_addr [2];
    logic        ob_v    [2];
    logic [31:0] ob_pc   [2];
    logic [31:0] ob_in   [2];
    assign ob_en[0] = bus1.imem_en;     assign ob_en[1] = bus3.imem_en;
    assign ob_addr[0] = bus1.imem_addr; assign ob_addr[1] = bus3.imem_addr;
    assign ob_v[0] = bus1.instr_valid;  assign ob_v[1] = bus3.instr_valid;
    assign ob_pc[0] = bus1.instr_pc;    assign ob_pc[1] = bus3.instr_pc;
    assign ob_in[0] = bus1.instr;       assign ob_in[1] = bus3.instr;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Each lane keeps the fetches it has issued and not yet consumed, in
    // order, with the cycle from which each becomes visible at the output.
    int          lat   [2];
    logic [31:0] m_fpc [2];
    logic [31:0] q_pc  [2][8];
    int          q_due [2][8];
    int          q_n   [2];
    int          cyc;

    bit          d_rst;
    bit          d_redir;
    bit          d_pop  [2];
    bit          d_en   [2];
    logic [31:0] d_addr [2];

    task automatic model_advance();
        for (int l = 0; l < 2; l++) begin
            if (d_rst) begin
                q_n[l]   = 0;
                m_fpc[l] = 32'h0;
            end else begin
                if (d_pop[l]) begin
                    for (int i = 0; i < 7; i++) begin
                        q_pc[l][i]  = q_pc[l][i+1];
                        q_due[l][i] = q_due[l][i+1];
                    end
                    q_n[l]--;
                end
                if (d_redir) q_n[l] = 0;
                if (d_en[l]) begin
                    q_pc[l][q_n[l]]  = d_addr[l];
                    q_due[l][q_n[l]] = cyc + lat[l] + 1;
                    q_n[l]++;
                    m_fpc[l] = d_addr[l] + 32'd4;
                end
            end
        end
        cyc++;
    endtask

    task automatic predict_check();
        bit          vis;
        bit          pop;
        bit          cred;
        bit          en;
        logic [31:0] e_pc;
        logic [31:0] addr;
        d_rst   = (rst == 1'b0);
        d_redir = redirect && rst;
        for (int l = 0; l < 2; l++) begin
            vis  = rst && (q_n[l] > 0) && (q_due[l][0] <= cyc);
            e_pc = vis ? q_pc[l][0] : 32'h0;
            pop  = vis && !stall && !redirect;
            cred = redirect || ((q_n[l] - int'(pop)) < DEPTH);
            en   = rst && cred;
            addr = redirect ? (redirect_pc & 32'hFFFF_FFFC) : (rst ? m_fpc[l] : 32'h0);
            chk($sformatf("L%0d.instr_valid", l), 32'(ob_v[l]), 32'(vis));
            chk($sformatf("L%0d.instr_pc", l),    ob_pc[l],     e_pc);
            chk($sformatf("L%0d.instr", l),       ob_in[l],     e_pc >> 2);
            chk($sformatf("L%0d.imem_en", l),     32'(ob_en[l]), 32'(en));
            chk($sformatf("L%0d.imem_addr", l),   ob_addr[l],   addr);
            d_pop[l]  = pop;
            d_en[l]   = en;
            d_addr[l] = addr;
        end
    endtask

    // One clock cycle: retire last cycle in the model, apply new inputs,
    // then compare at the falling edge.
    task automatic cycle(input bit r, input bit st, input bit rd, input logic [31:0] rp);
        @(posedge clk);
        model_advance();
        #1;
        rst = r; stall = st; redirect = rd; redirect_pc = rp;
        #1;
        if (!rst) begin
            for (int l = 0; l < 2; l++) begin
                chk($sformatf("L%0d.async_rst_valid", l), 32'(ob_v[l]), 32'h0);
                chk($sformatf("L%0d.async_rst_pc", l),    ob_pc[l],     32'h0);
                chk($sformatf("L%0d.async_rst_instr", l), ob_in[l],     32'h0);
            end
        end
        @(negedge clk);
        predict_check();
    endtask

    initial begin
        lat[0] = 1; lat[1] = 3;
        q_n[0] = 0; q_n[1] = 0;
        m_fpc[0] = 0; m_fpc[1] = 0;
        cyc = 0; d_rst = 1'b1; d_redir = 1'b0;
        for (int l = 0; l < 2; l++) begin d_pop[l] = 0; d_en[l] = 0; d_addr[l] = 0; end
        rst = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;

        // Reset held, then release and stream
        repeat (3) cycle(1'b0, 1'b0, 1'b0, 32'h0);
        repeat (12) cycle(1'b1, 1'b0, 1'b0, 32'h0);

        // Long stall then release
        repeat (6) cycle(1'b1, 1'b1, 1'b0, 32'h0);
        repeat (5) cycle(1'b1, 1'b0, 1'b0, 32'h0);

        // Redirect with words queued and in flight
        repeat (2) cycle(1'b1, 1'b1, 1'b0, 32'h0);
        cycle(1'b1, 1'b0, 1'b1, 32'h40);
        repeat (6) cycle(1'b1, 1'b0, 1'b0, 32'h0);

        // Redirect and stall together, unaligned target
        cycle(1'b1, 1'b1, 1'b1, 32'h103);
        repeat (5) cycle(1'b1, 1'b0, 1'b0, 32'h0);

        // Sustained throughput on the MEM_LAT=3 lane
        cycle(1'b1, 1'b0, 1'b1, 32'h200);
        repeat (4) cycle(1'b1, 1'b0, 1'b0, 32'h0);
        for (int i = 0; i < 20; i++) begin
            cycle(1'b1, 1'b0, 1'b0, 32'h0);
            chk("L1.throughput_valid", 32'(ob_v[1]), 32'h1);
        end

        // One-cycle reset mid-stream
        cycle(1'b0, 1'b0, 1'b0, 32'h0);
        repeat (10) cycle(1'b1, 1'b0, 1'b0, 32'h0);

        // Random traffic
        for (int i = 0; i < 500; i++) begin
            cycle(($urandom_range(0, 99) != 0),
                  ($urandom_range(0, 99) < 30),
                  ($urandom_range(0, 99) < 8),
                  32'($urandom_range(0, 1023)));
        end
        repeat (8) cycle(1'b1, 1'b0, 1'b0, 32'h0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
`default_nettype wire
